// File: rtl/addr_gen_pkg.sv
// Shared definitions for addr_gen: state bit positions, reset PC default,
// decoded-state and address-mux select encodings, and the priority state decoder.
package addr_gen_pkg;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'hFFFC;

    localparam int N_ST  = 6;
    localparam int B_SOP = 0;
    localparam int B_SLO = 1;
    localparam int B_SIN = 2;
    localparam int B_SHI = 3;
    localparam int B_SCO = 4;
    localparam int B_SLR = 5;

    typedef enum logic [2:0] {
        ST_NONE, ST_S0, ST_SOP, ST_SLO, ST_SIN, ST_SHI, ST_SCO, ST_SLR
    } state_e;

    typedef enum logic [2:0] {
        SEL_PC, SEL_PTR, SEL_PTR_HI, SEL_SCO, SEL_EA
    } addr_sel_e;

    // Several state bits high at once resolve to SOP, then SLR, SCO, SHI, SIN, SLO.
    function automatic state_e decode_state(input logic s0, input logic [N_ST-1:0] st);
        state_e r;
        if (st[B_SOP])      r = ST_SOP;
        else if (st[B_SLR]) r = ST_SLR;
        else if (st[B_SCO]) r = ST_SCO;
        else if (st[B_SHI]) r = ST_SHI;
        else if (st[B_SIN]) r = ST_SIN;
        else if (st[B_SLO]) r = ST_SLO;
        else if (s0)        r = ST_S0;
        else                r = ST_NONE;
        return r;
    endfunction

endpackage

// File: rtl/addr_gen_if.sv
// Bus between the sequencing FSM (master) and addr_gen (slave).
interface addr_gen_if;
    import addr_gen_pkg::*;

    logic            s0;
    logic [N_ST-1:0] st;
    logic            imm;
    logic [7:0]      din;
    logic [7:0]      idx;
    logic [15:0]     addr;
    logic            ci;
    logic            sync;

    modport master (output s0, st, imm, din, idx, input addr, ci, sync);
    modport slave  (input s0, st, imm, din, idx, output addr, ci, sync);
endinterface

// File: rtl/addr_gen_pc_counter.sv
// 16-bit program counter: async reset to RESET_PC, increments when enabled, wraps silently.
module addr_gen_pc_counter #(
    parameter logic [15:0] RESET_PC = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    output logic [15:0] o_pc
);

    logic [15:0] r_pc;

    // PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_pc <= RESET_PC;
        else if (i_inc) r_pc <= r_pc + 16'h0001;
        else            r_pc <= r_pc;
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/addr_gen.sv
// Address generator: drives the address bus per state, owns the PC, latches operands.
// Optional macro NMOS_ZP_WRAP_EN keeps the indirect pointer high-byte fetch inside page 0.
module addr_gen
    import addr_gen_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    addr_gen_if.slave    bus
);

    logic [7:0]  r_lo, r_hi, r_ptr;
    logic        r_ind_f, r_imm_f, r_zp_f, r_co_q;

    state_e      w_state;
    addr_sel_e   w_sel;
    logic [8:0]  w_sum;
    logic [15:0] w_pc, w_ptr_hi_addr, w_ea;
    logic        w_pc_inc;

    assign w_state = decode_state(bus.s0, bus.st);
    assign w_sum   = {1'b0, r_lo} + {1'b0, bus.idx};
    // Zero-page path never carries into the high byte.
    assign w_ea    = r_zp_f ? {8'h00, w_sum[7:0]}
                            : {r_hi + {7'h00, r_co_q}, w_sum[7:0]};

`ifdef NMOS_ZP_WRAP_EN
    assign w_ptr_hi_addr = {8'h00, r_ptr + 8'h01};
`else
    assign w_ptr_hi_addr = {8'h00, r_ptr} + 16'h0001;
`endif

    assign bus.ci   = (w_state == ST_SHI) ? w_sum[8] : 1'b0;
    assign bus.sync = bus.st[B_SOP];

    addr_gen_pc_counter #(.RESET_PC(RESET_PC)) u_pc (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_pc_inc),
        .o_pc  (w_pc)
    );

    // PC increment enable per state
    always_comb begin
        w_pc_inc = 1'b0;
        case (w_state)
            ST_SOP:  w_pc_inc = 1'b1;
            ST_SLO:  w_pc_inc = 1'b1;
            ST_SHI:  w_pc_inc = ~r_ind_f;
            ST_SLR:  w_pc_inc = r_imm_f;
            default: w_pc_inc = 1'b0;
        endcase
    end

    // Address source select per state
    always_comb begin
        w_sel = SEL_PC;
        case (w_state)
            ST_SIN:  w_sel = SEL_PTR;
            ST_SHI:  w_sel = r_ind_f ? SEL_PTR_HI : SEL_PC;
            ST_SCO:  w_sel = SEL_SCO;
            ST_SLR:  w_sel = r_imm_f ? SEL_PC : SEL_EA;
            default: w_sel = SEL_PC;
        endcase
    end

    // Address bus mux
    always_comb begin
        bus.addr = w_pc;
        case (w_sel)
            SEL_PTR:    bus.addr = {8'h00, r_ptr};
            SEL_PTR_HI: bus.addr = w_ptr_hi_addr;
            SEL_SCO:    bus.addr = {r_hi, w_sum[7:0]};
            SEL_EA:     bus.addr = w_ea;
            default:    bus.addr = w_pc;
        endcase
    end

    // Operand bytes and mode flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo    <= 8'h00;
            r_hi    <= 8'h00;
            r_ptr   <= 8'h00;
            r_ind_f <= 1'b0;
            r_imm_f <= 1'b0;
            r_zp_f  <= 1'b0;
            r_co_q  <= 1'b0;
        end else begin
            case (w_state)
                ST_SOP: begin
                    r_imm_f <= bus.imm;
                    r_ind_f <= 1'b0;
                    r_zp_f  <= 1'b1;
                end
                ST_SLO: begin
                    r_lo  <= bus.din;
                    r_ptr <= bus.din;
                end
                ST_SIN: begin
                    r_lo    <= bus.din;
                    r_ind_f <= 1'b1;
                end
                ST_SHI: begin
                    r_hi   <= bus.din;
                    r_zp_f <= 1'b0;
                    r_co_q <= bus.ci;
                end
                ST_SLR: begin
                    r_imm_f <= 1'b0;
                    r_ind_f <= 1'b0;
                    r_co_q  <= 1'b0;
                end
                default: begin
                    r_lo <= r_lo;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_gen.sv
// Self-checking bench for addr_gen: directed vectors, a mid-instruction reset,
// then random instruction streams against an instruction-level reference model.
module tb_addr_gen;

    localparam logic [5:0] M_SOP = 6'b000001;
    localparam logic [5:0] M_SLO = 6'b000010;
    localparam logic [5:0] M_SIN = 6'b000100;
    localparam logic [5:0] M_SHI = 6'b001000;
    localparam logic [5:0] M_SCO = 6'b010000;
    localparam logic [5:0] M_SLR = 6'b100000;

    localparam int K_IMM  = 0;
    localparam int K_ZPY  = 1;
    localparam int K_ABSY = 2;
    localparam int K_INDY = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addr_gen_if bus ();

    addr_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_pc;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One state cycle: drive after the rising edge, check on the falling edge.
    task automatic cyc(input string tag, input logic [5:0] st, input logic [7:0] din,
                       input logic imm, input logic [15:0] e_addr, input logic e_ci,
                       input logic e_sync);
        bus.st  = st;
        bus.s0  = (st == 6'b000000);
        bus.din = din;
        bus.imm = imm;
        @(negedge clk);
        chk({tag, ".addr"}, bus.addr, e_addr);
        chk({tag, ".ci"},   16'(bus.ci), 16'(e_ci));
        chk({tag, ".sync"}, 16'(bus.sync), 16'(e_sync));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ptr_hi(input logic [7:0] p);
        int v;
`ifdef NMOS_ZP_WRAP_EN
        v = (int'(p) + 1) % 256;
`else
        v = int'(p) + 1;
`endif
        return 16'(v);
    endfunction

    // Plays one whole instruction through the bus; expectations from addressing-mode arithmetic.
    task automatic instr(input int kind, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] idx, input bit noisy);
        logic [15:0] ea;
        logic [7:0]  lo, hi;
        logic        carry;
        logic [5:0]  x_sop, x_slr;
        x_sop = noisy ? (6'($urandom) & 6'b111110) : 6'b000000;
        x_slr = noisy ? (6'($urandom) & 6'b011110) : 6'b000000;
        bus.idx = idx;
        if (noisy && $urandom_range(0, 1) == 0)
            cyc("s0", 6'b000000, 8'($urandom), 1'b0, m_pc, 1'b0, 1'b0);
        cyc("sop", M_SOP | x_sop, 8'($urandom), (kind == K_IMM), m_pc, 1'b0, 1'b1);
        m_pc = m_pc + 16'd1;
        if (kind == K_IMM) begin
            cyc("imm.slr", M_SLR | x_slr, 8'($urandom), 1'b0, m_pc, 1'b0, 1'b0);
            m_pc = m_pc + 16'd1;
            return;
        end
        cyc("slo", M_SLO, a, 1'b0, m_pc, 1'b0, 1'b0);
        m_pc = m_pc + 16'd1;
        if (kind == K_ZPY) begin
            ea = 16'((int'(a) + int'(idx)) % 256);
            cyc("zpy.slr", M_SLR | x_slr, 8'($urandom), 1'b0, ea, 1'b0, 1'b0);
            return;
        end
        if (kind == K_INDY) begin
            cyc("indy.sin", M_SIN, b, 1'b0, {8'h00, a}, 1'b0, 1'b0);
            lo = b;
            hi = c;
            carry = (int'(lo) + int'(idx)) > 255;
            cyc("indy.shi", M_SHI, hi, 1'b0, ptr_hi(a), carry, 1'b0);
        end else begin
            lo = a;
            hi = b;
            carry = (int'(lo) + int'(idx)) > 255;
            cyc("absy.shi", M_SHI, hi, 1'b0, m_pc, carry, 1'b0);
            m_pc = m_pc + 16'd1;
        end
        if (carry)
            cyc("sco", M_SCO, 8'($urandom), 1'b0,
                {hi, 8'((int'(lo) + int'(idx)) % 256)}, 1'b0, 1'b0);
        ea = 16'((int'({hi, lo}) + int'(idx)) % 65536);
        cyc("ea.slr", M_SLR | x_slr, 8'($urandom), 1'b0, ea, 1'b0, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        bus.st  = 6'b000000;
        bus.s0  = 1'b0;
        bus.imm = 1'b0;
        bus.din = 8'h00;
        bus.idx = 8'h00;
        m_pc    = 16'hFFFC;
        #12;
        chk("rst.addr", bus.addr, 16'hFFFC);
        chk("rst.ci",   16'(bus.ci), 16'h0000);
        chk("rst.sync", 16'(bus.sync), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        cyc("boot.s0", 6'b000000, 8'h00, 1'b0, 16'hFFFC, 1'b0, 1'b0);
        instr(K_IMM,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        instr(K_ABSY, 8'h10, 8'h20, 8'h00, 8'h05, 1'b0);
        instr(K_ABSY, 8'hF0, 8'h12, 8'h00, 8'h20, 1'b0);
        instr(K_INDY, 8'hFF, 8'h34, 8'h56, 8'h01, 1'b0);
        instr(K_ZPY,  8'hF0, 8'h00, 8'h00, 8'h20, 1'b0);
        instr(K_ABSY, 8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0);

        // Async reset pulse in the middle of a high-byte fetch.
        bus.idx = 8'h20;
        cyc("mr.sop", M_SOP, 8'h00, 1'b0, m_pc, 1'b0, 1'b1);
        m_pc = m_pc + 16'd1;
        cyc("mr.slo", M_SLO, 8'hF0, 1'b0, m_pc, 1'b0, 1'b0);
        m_pc = m_pc + 16'd1;
        bus.st  = M_SHI;
        bus.s0  = 1'b0;
        bus.din = 8'h12;
        #2;
        chk("mr.pre.ci", 16'(bus.ci), 16'h0001);
        rst = 1'b1;
        #1;
        chk("mr.addr", bus.addr, 16'hFFFC);
        chk("mr.ci",   16'(bus.ci), 16'h0000);
        bus.st = 6'b000000;
        bus.s0 = 1'b1;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_pc = 16'hFFFC;
        instr(K_ZPY,  8'h80, 8'h00, 8'h00, 8'h01, 1'b0);
        instr(K_ABSY, 8'h40, 8'h33, 8'h00, 8'h02, 1'b0);

        for (int i = 0; i < 300; i++)
            instr($urandom_range(0, 3), 8'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
